// File: rtl/calc_result_bcd.sv
// Sequential signed binary-to-BCD converter for the calculator display path.
// Iterative double-dabble: one magnitude bit per clock, single-cycle done pulse.
module calc_result_bcd #(
  parameter int nb   = 40,
  parameter int NDIG = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [nb-1:0]     result,
  output logic              busy,
  output logic              done,
  output logic              sign,
  output logic [4*NDIG-1:0] digits,
  output logic              ovf
);

  // Enough digits that no intermediate value of any nb-bit magnitude is lost.
  localparam int NINT = NDIG + (nb * 302 + 999) / 1000 + 1;
  localparam int AW   = 4 * NINT;
  localparam int CW   = $clog2(nb + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  function automatic logic [AW-1:0] add3_digits(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = a;
    for (int i = 0; i < NINT; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = a[4*i +: 4];
      end
    end
    return r;
  endfunction

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic [AW-1:0]     acc_r;
  logic [nb-1:0]     mag_r;
  logic              sign_lat_r;
  logic              busy_r;
  logic              done_r;
  logic              sign_r;
  logic [4*NDIG-1:0] digits_r;
  logic              ovf_r;

  logic [nb-1:0]     abs_s;
  logic [AW-1:0]     acc_adj_s;
  logic [AW-1:0]     acc_shift_s;
  logic [nb-1:0]     mag_shift_s;
  logic              ovf_s;

  // Magnitude of the incoming result and one double-dabble step of the engine.
  always_comb begin
    abs_s       = {nb{1'b0}};
    acc_adj_s   = {AW{1'b0}};
    acc_shift_s = {AW{1'b0}};
    mag_shift_s = {nb{1'b0}};
    ovf_s       = 1'b0;
    if (result[nb-1]) begin
      abs_s = ~result + {{(nb-1){1'b0}}, 1'b1};
    end else begin
      abs_s = result;
    end
    acc_adj_s   = add3_digits(acc_r);
    acc_shift_s = {acc_adj_s[AW-2:0], mag_r[nb-1]};
    mag_shift_s = {mag_r[nb-2:0], 1'b0};
    // A bit shifted out of the top digit can only ever mean overflow.
    ovf_s       = (|acc_shift_s[AW-1:4*NDIG]) | acc_adj_s[AW-1];
  end

  // Control FSM, conversion datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      acc_r      <= {AW{1'b0}};
      mag_r      <= {nb{1'b0}};
      sign_lat_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      sign_r     <= 1'b0;
      digits_r   <= {(4*NDIG){1'b0}};
      ovf_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            sign_lat_r <= result[nb-1];
            mag_r      <= abs_s;
            acc_r      <= {AW{1'b0}};
            cnt_r      <= CW'(nb);
            busy_r     <= 1'b1;
            state_r    <= CONV;
          end else begin
            busy_r     <= 1'b0;
          end
        end
        CONV: begin
          acc_r <= acc_shift_s;
          mag_r <= mag_shift_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            sign_r   <= sign_lat_r;
            ovf_r    <= ovf_s;
            digits_r <= ovf_s ? {(4*NDIG){1'b0}} : acc_shift_s[4*NDIG-1:0];
          end else begin
            busy_r   <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign sign   = sign_r;
  assign digits = digits_r;
  assign ovf    = ovf_r;

endmodule

// File: tb/tb_calc_result_bcd.sv
// Directed bench: a 12-digit and a 3-digit converter fed the same stimulus,
// checked against hand-computed BCD values plus protocol corner sequences.
module tb_calc_result_bcd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [39:0] result;
  logic        busy0, done0, sign0, ovf0;
  logic [47:0] digits0;
  logic        busy1, done1, sign1, ovf1;
  logic [11:0] digits1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  calc_result_bcd #(.nb(40), .NDIG(12)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .result(result),
    .busy(busy0), .done(done0), .sign(sign0), .digits(digits0), .ovf(ovf0)
  );

  calc_result_bcd #(.nb(40), .NDIG(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .result(result),
    .busy(busy1), .done(done1), .sign(sign1), .digits(digits1), .ovf(ovf1)
  );

  typedef struct {
    logic [39:0] res;
    logic        sgn;
    logic [47:0] d12;
    logic [11:0] d3;
    logic        ovf3;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start with r; returns edges from accept to done and busy-cycle count.
  task automatic convert(input logic [39:0] r, output int lat, output int bcnt, output bit stable);
    logic [47:0] prev;
    prev   = digits0;
    stable = 1'b1;
    bcnt   = 0;
    @(negedge clk);
    result = r;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    lat    = 1;
    while (!done0 && lat < 60) begin
      if (busy0) bcnt++;
      if (digits0 !== prev) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int          lat, bcnt, first, second;
    bit          stable, seen;
    logic [63:0] rnd;

    tbl[0] = '{40'hFFFFFFFFF6, 1'b1, 48'h000000000010, 12'h010, 1'b0};
    tbl[1] = '{40'h7FFFFFFFFF, 1'b0, 48'h549755813887, 12'h000, 1'b1};
    tbl[2] = '{40'h8000000000, 1'b1, 48'h549755813888, 12'h000, 1'b1};
    tbl[3] = '{40'h0000000000, 1'b0, 48'h000000000000, 12'h000, 1'b0};
    tbl[4] = '{40'd999,        1'b0, 48'h000000000999, 12'h999, 1'b0};
    tbl[5] = '{40'd1000,       1'b0, 48'h000000001000, 12'h000, 1'b1};
    tbl[6] = '{40'hFFFFFFFC18, 1'b1, 48'h000000001000, 12'h000, 1'b1};
    tbl[7] = '{40'd123,        1'b0, 48'h000000000123, 12'h123, 1'b0};
    tbl[8] = '{40'hFFFFFFFFFF, 1'b1, 48'h000000000001, 12'h001, 1'b0};
    tbl[9] = '{40'd987654,     1'b0, 48'h000000987654, 12'h000, 1'b1};

    // Reset held with start asserted and random operand.
    rst_n  = 1'b0;
    start  = 1'b1;
    rnd    = {$urandom(), $urandom()};
    result = rnd[39:0];
    seen   = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done0 || done1 || busy0) seen = 1'b1;
    end
    chk("rst_activity", {63'd0, seen}, 64'd0);
    chk("rst_outputs", {sign0, ovf0, digits0, sign1, ovf1, digits1}, 64'd0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_outputs", {busy0, done0, sign0, ovf0, digits0, busy1, done1, sign1, ovf1}, 64'd0);

    for (int i = 0; i < 10; i++) begin
      convert(tbl[i].res, lat, bcnt, stable);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd41);
      chk($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'd40);
      chk($sformatf("v%0d_stable", i), {63'd0, stable}, 64'd1);
      chk($sformatf("v%0d_busy_at_done", i), {62'd0, busy0, busy1}, 64'd0);
      chk($sformatf("v%0d_done_n3", i), {63'd0, done1}, 64'd1);
      chk($sformatf("v%0d_sign", i), {62'd0, sign0, sign1}, {62'd0, tbl[i].sgn, tbl[i].sgn});
      chk($sformatf("v%0d_digits12", i), 64'(digits0), 64'(tbl[i].d12));
      chk($sformatf("v%0d_ovf12", i), {63'd0, ovf0}, 64'd0);
      chk($sformatf("v%0d_digits3", i), 64'(digits1), 64'(tbl[i].d3));
      chk($sformatf("v%0d_ovf3", i), {63'd0, ovf1}, {63'd0, tbl[i].ovf3});
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {62'd0, done0, done1}, 64'd0);
    end

    // start held high: back-to-back conversions every 41 clocks.
    @(negedge clk);
    result = 40'd123;
    start  = 1'b1;
    first  = 0;
    second = 0;
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      if (done0) begin
        if (first == 0) first = c;
        else if (second == 0) second = c;
        chk("held_digits", 64'(digits0), 64'h123);
      end
    end
    start = 1'b0;
    chk("held_first_done", 64'(first), 64'd41);
    chk("held_second_done", 64'(second), 64'd82);
    for (int c = 0; c < 60 && busy0; c++) @(negedge clk);
    @(negedge clk);

    // start pulsed mid-conversion is ignored, not queued.
    result = 40'd456;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    repeat (9) begin @(negedge clk); lat++; end
    result = 40'd7;
    start  = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!done0 && lat < 60) begin @(negedge clk); lat++; end
    chk("midstart_latency", 64'(lat), 64'd41);
    chk("midstart_digits", 64'(digits0), 64'h456);
    seen = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (done0 || busy0) seen = 1'b1;
    end
    chk("midstart_not_queued", {63'd0, seen}, 64'd0);

    // Reset in the middle of a conversion aborts it.
    result = 40'd999;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy0, done0, sign0, ovf0, digits0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done0 || busy0) seen = 1'b1;
    end
    chk("abort_no_done", {63'd0, seen}, 64'd0);
    convert(40'd123, lat, bcnt, stable);
    chk("after_abort_latency", 64'(lat), 64'd41);
    chk("after_abort_digits", 64'(digits0), 64'h123);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/calc_result_bcd.md
# calc_result_bcd

Sequential binary-to-BCD converter that sits on the output side of the `calculator` datapath. It samples a signed `nb`-bit `result` on a start strobe and produces sign, `NDIG` packed BCD digits and an overflow flag for the display stage. It uses an iterative double-dabble (shift-and-add-3) engine, one result bit per clock, with a single-cycle `done` pulse.

## Interface

Parameters:
- `nb`, 40, width of the signed two's-complement `result` input (same `nb` as the calculator instance)
- `NDIG`, 12, number of BCD digits presented on `digits`

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request conversion of `result`; sampled only when `busy`=0
- `result`  in  `nb`  signed calculator result, sampled on the accepting edge only
- `busy`  out  1  conversion in progress
- `done`  out  1  one-cycle pulse: `sign`/`digits`/`ovf` just updated
- `sign`  out  1  1 = captured result was negative
- `digits`  out  `4*NDIG`  packed BCD, digit 0 (units) in bits [3:0]
- `ovf`  out  1  magnitude ≥ 10^NDIG

## Operation

- States: IDLE, CONV.
- IDLE, `start`=1: latch `sign` = result[nb-1]; latch magnitude = |result| as unsigned `nb` bits. -2^(nb-1) maps to 2^(nb-1) with no wrap. Clear internal BCD accumulator, load bit counter = `nb`, go to CONV.
- Internal accumulator width is NINT = NDIG + ceil(nb*0.302) + 1 digits, so no intermediate loss for any `nb`/`NDIG`.
- CONV, each cycle:
  - add 3 to every accumulator digit ≥ 5;
  - shift {accumulator, magnitude} left by 1 (magnitude MSB enters digit 0 LSB);
  - decrement counter.
- CONV, on the cycle the counter goes 1→0: register outputs, go to IDLE.
  - `ovf` = any accumulator digit at index ≥ NDIG nonzero.
  - `digits` = low NDIG accumulator digits when `ovf`=0, all-zero when `ovf`=1.
  - `sign` = latched sign.
- Zero result: `sign`=0, `digits`=0, `ovf`=0.
- Outputs hold their last values until the next `done`; they do not change during CONV.
- `start` while `busy`=1 is ignored; it is not queued.

## Timing

- Reset (async assert, any state): state IDLE, `busy`=0, `done`=0, `sign`=0, `digits`=0, `ovf`=0, counter and accumulators 0.
- Reset mid-conversion aborts the conversion; no `done` is produced.
- Reset deassertion is synchronous to `clk` at the source.
- `start` accepted at edge k:
  - `busy`=1 after edges k … k+nb−1;
  - after edge k+nb: `busy`=0, `done`=1, outputs valid;
  - after edge k+nb+1: `done`=0.
- Latency start→done = nb+1 clocks (41 for nb=40). Throughput: one conversion per nb+1 clocks.
- `start` sampled high in the same cycle `done`=1 (state IDLE) is accepted. Back-to-back conversions have no bubble.
- `done` is never high for more than one cycle, and never high together with `busy`.

## Test plan

- Reset: hold `rst_n`=0 with `start`=1 and random `result` → all outputs 0, no `done`. Release, idle 5 cycles → outputs stay 0.
- result=−10, start pulse → `done` exactly 41 clocks later; `sign`=1, `digits`=48'h000000000010, `ovf`=0; `busy` high for exactly 40 cycles.
- result=2^39−1 → `digits`=48'h549755813887, `sign`=0. Then result=−2^39 → `digits`=48'h549755813888, `sign`=1, `ovf`=0.
- result=0 → `digits`=0, `sign`=0, `ovf`=0.
- Second instance with NDIG=3: result=999 → `digits`=12'h999, `ovf`=0. Result=1000 → `ovf`=1, `digits`=0. Result=−1000 → `ovf`=1, `sign`=1.
- Protocol:
  - `start` held high continuously with result=123 → `done` every 41 clocks, each with `digits`=…123.
  - `start` pulsed mid-CONV with result=7 → ignored; first result kept.
  - `rst_n` pulsed low at cycle 20 of a conversion → no `done`, outputs 0, next `start` converts normally.
